// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a single-port synchronous RAM
module ram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] ramDataIn,
    input  logic [DATA_WIDTH-1:0] ramDataOut,
    output logic                  busy,
    output logic                  grant_b
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t state;
    logic   lat_we;
    logic   elig_a;
    logic   elig_b;
    logic   win_b;
    logic   win_we;

    // A port is not eligible during its own ack cycle, so a held request is not re-granted.
    assign elig_a = req_a & ~ack_a;
    assign elig_b = req_b & ~ack_b;
    // On a tie the port that did not win last time goes next.
    assign win_b  = elig_b & (~elig_a | ~grant_b);
    assign win_we = win_b ? we_b : we_a;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            address   <= '0;
            ramDataIn <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            busy      <= 1'b0;
            grant_b   <= 1'b1;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig_a | elig_b) begin
                        grant_b   <= win_b;
                        lat_we    <= win_we;
                        address   <= win_b ? addr_b : addr_a;
                        ramDataIn <= win_b ? wdata_b : wdata_a;
                        write     <= win_we;
                        read      <= ~win_we;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    read  <= 1'b0;
                    write <= 1'b0;
                    state <= COMPLETE;
                end
                COMPLETE: begin
                    if (grant_b) begin
                        ack_b <= 1'b1;
                        if (!lat_we) rdata_b <= ramDataOut;
                    end else begin
                        ack_a <= 1'b1;
                        if (!lat_we) rdata_a <= ramDataOut;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    read  <= 1'b0;
                    write <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural synchronous RAM
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        req_a, we_a, req_b, we_b;
    logic [8:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        ack_a, ack_b;
    logic [31:0] rdata_a, rdata_b;
    logic        read, write;
    logic [8:0]  address;
    logic [31:0] ramDataIn;
    logic [31:0] ramDataOut;
    logic        busy, grant_b;

    ram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .clock(clock), .clear_n(clear_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_a(ack_a), .rdata_a(rdata_a), .ack_b(ack_b), .rdata_b(rdata_b),
        .read(read), .write(write), .address(address), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut), .busy(busy), .grant_b(grant_b)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [512];
    always @(posedge clock) begin
        if (write) mem[address] <= ramDataIn;
        if (read)  ramDataOut   <= mem[address];
    end

    typedef struct {
        bit          is_b;
        logic [31:0] ea;
        logic [31:0] eb;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [512];
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [8:0]  last_wr_addr = 9'h0;
    bit          spacing_on = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input bit is_b, input bit we, input logic [8:0] addr,
                              input logic [31:0] wd, input string tag);
        if (we) mdl[addr] = wd;
        else if (is_b) last_b = mdl[addr];
        else last_a = mdl[addr];
        sbq.push_back('{is_b, last_a, last_b, tag});
    endtask

    task automatic drive(input bit is_b, input bit we, input logic [8:0] addr,
                         input logic [31:0] wd, output int lat);
        int n;
        int start;
        if (is_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
        else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
        start = cyc;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(is_b ? ack_b : ack_a) && n < 40);
        if (!(is_b ? ack_b : ack_a)) check("drive_timeout", 64'd0, 64'd1);
        if (is_b) req_b = 1'b0; else req_a = 1'b0;
        lat = cyc - start;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack_a"}, ack_a, 0);
        check({tag, "_ack_b"}, ack_b, 0);
        check({tag, "_rdata_a"}, rdata_a, 0);
        check({tag, "_rdata_b"}, rdata_b, 0);
        check({tag, "_read"}, read, 0);
        check({tag, "_write"}, write, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_ramDataIn"}, ramDataIn, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_b"}, grant_b, 1);
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (clear_n === 1'b1) begin
            if (read || write) check("rw_exclusive", read && write, 0);
            if (write) begin
                wr_cnt++;
                last_wr_addr = address;
            end
            if (ack_a || ack_b) begin
                exp_t e;
                check("ack_both", ack_a && ack_b, 0);
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check({e.tag, "_port"}, ack_b, e.is_b);
                    check({e.tag, "_grant_b"}, grant_b, e.is_b);
                    check({e.tag, "_rdata_a"}, rdata_a, e.ea);
                    check({e.tag, "_rdata_b"}, rdata_b, e.eb);
                end
                if (spacing_on && have_prev) check("ack_spacing", cyc - prev_cyc, 3);
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, n, w0;
        clear_n = 1'b0;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        repeat (2) @(negedge clock);
        check_reset_outputs("rst");
        clear_n = 1'b1;

        // simultaneous requests right after reset: A first, B back-to-back
        expect_txn(0, 1, 9'h030, 32'hA0A0A0A0, "tie_a");
        expect_txn(1, 1, 9'h031, 32'hB0B0B0B0, "tie_b");
        spacing_on = 1'b1;
        have_prev  = 1'b0;
        fork
            drive(0, 1, 9'h030, 32'hA0A0A0A0, la);
            drive(1, 1, 9'h031, 32'hB0B0B0B0, lb);
        join
        spacing_on = 1'b0;

        // write then read back on port A
        w0 = wr_cnt;
        expect_txn(0, 1, 9'h1A5, 32'hDEADBEEF, "a_wr");
        drive(0, 1, 9'h1A5, 32'hDEADBEEF, la);
        check("a_wr_cycles", wr_cnt - w0, 1);
        check("a_wr_addr", last_wr_addr, 9'h1A5);
        @(negedge clock);
        expect_txn(0, 0, 9'h1A5, 32'h0, "a_rd");
        drive(0, 0, 9'h1A5, 32'h0, la);
        check("a_rd_latency", la, 3);

        // port B at the address boundaries
        expect_txn(1, 1, 9'h000, 32'h11111111, "b_wr0");
        drive(1, 1, 9'h000, 32'h11111111, lb);
        expect_txn(1, 1, 9'h1FF, 32'h22222222, "b_wr1ff");
        drive(1, 1, 9'h1FF, 32'h22222222, lb);
        expect_txn(1, 0, 9'h000, 32'h0, "b_rd0");
        drive(1, 0, 9'h000, 32'h0, lb);
        expect_txn(1, 0, 9'h1FF, 32'h0, "b_rd1ff");
        drive(1, 0, 9'h1FF, 32'h0, lb);
        check("b_rdata_a_hold", rdata_a, 32'hDEADBEEF);

        // continuous traffic on both ports alternates
        expect_txn(0, 1, 9'h020, 32'h00000001, "rr_a0");
        expect_txn(1, 1, 9'h021, 32'h00000002, "rr_b0");
        expect_txn(0, 0, 9'h021, 32'h0, "rr_a1");
        expect_txn(1, 0, 9'h020, 32'h0, "rr_b1");
        expect_txn(0, 1, 9'h022, 32'h00000033, "rr_a2");
        expect_txn(1, 0, 9'h022, 32'h0, "rr_b2");
        spacing_on = 1'b1;
        have_prev  = 1'b0;
        fork
            begin
                int l1;
                drive(0, 1, 9'h020, 32'h00000001, l1);
                drive(0, 0, 9'h021, 32'h0, l1);
                drive(0, 1, 9'h022, 32'h00000033, l1);
            end
            begin
                int l2;
                drive(1, 1, 9'h021, 32'h00000002, l2);
                drive(1, 0, 9'h020, 32'h0, l2);
                drive(1, 0, 9'h022, 32'h0, l2);
            end
        join
        spacing_on = 1'b0;

        // reset during ACCESS of a write aborts it
        expect_txn(0, 1, 9'h010, 32'h12345678, "pre_wr");
        drive(0, 1, 9'h010, 32'h12345678, la);
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b1; addr_a = 9'h010; wdata_a = 32'hBAD0BAD0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!write && n < 20);
        check("abort_saw_access", write, 1);
        clear_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        req_a = 1'b0;
        last_a = 32'h0;
        last_b = 32'h0;
        @(negedge clock);
        @(negedge clock);
        check("abort_no_ack", ack_a, 0);
        clear_n = 1'b1;
        @(negedge clock);
        expect_txn(0, 0, 9'h010, 32'h0, "post_rd");
        drive(0, 0, 9'h010, 32'h0, la);

        // held request with address changed after grant
        expect_txn(0, 1, 9'h040, 32'h44444444, "hold_px");
        drive(0, 1, 9'h040, 32'h44444444, la);
        @(negedge clock);
        expect_txn(0, 1, 9'h041, 32'h55555555, "hold_py");
        drive(0, 1, 9'h041, 32'h55555555, la);
        @(negedge clock);
        expect_txn(0, 0, 9'h040, 32'h0, "hold_rx");
        expect_txn(0, 0, 9'h041, 32'h0, "hold_ry");
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'h040;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!busy && n < 20);
        check("hold_granted", busy, 1);
        addr_a = 9'h041;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ack_a && n < 20);
        check("hold_ack1", ack_a, 1);
        @(negedge clock);
        check("hold_no_regrant", busy, 0);
        @(negedge clock);
        check("hold_regrant_later", busy, 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ack_a && n < 20);
        check("hold_ack2", ack_a, 1);
        req_a = 1'b0;

        repeat (4) @(negedge clock);
        check("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
